// File: rtl/z88_kbd_pkg.sv
// z88_kbd_pkg: shared definitions for the Z88 PS/2 keyboard front end.
//   - PS/2 set-2 scan-code constants (prefixes, BAT, overrun codes)
//   - receiver and decoder state encodings
//   - keymap lookup: {ext, code} -> {hit, matrix index 8*row+col}
package z88_kbd_pkg;

    localparam logic [7:0] SC_E0         = 8'hE0;
    localparam logic [7:0] SC_E1         = 8'hE1;
    localparam logic [7:0] SC_F0         = 8'hF0;
    localparam logic [7:0] SC_AA         = 8'hAA;
    localparam logic [7:0] SC_OVR_00     = 8'h00;
    localparam logic [7:0] SC_OVR_FF     = 8'hFF;
    localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;

    // Bytes that follow E1 in the pause-key sequence
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        DEC_BASE,
        DEC_E0,
        DEC_F0,
        DEC_E0F0,
        DEC_SKIP
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [5:0] idx;
    } key_hit_t;

    function automatic key_hit_t keymap(input logic ext, input logic [7:0] code);
        key_hit_t r;
        r = '0;
        case ({ext, code})
            {1'b0, 8'h1C}: r = {1'b1, 6'd30};  // A
            {1'b0, 8'h5A}: r = {1'b1, 6'd6};   // Enter
            {1'b0, 8'h12}: r = {1'b1, 6'd62};  // Left shift
            {1'b0, 8'h59}: r = {1'b1, 6'd63};  // Right shift
            {1'b0, 8'h29}: r = {1'b1, 6'd46};  // Space
            {1'b1, 8'h75}: r = {1'b1, 6'd55};  // Up
            {1'b1, 8'h72}: r = {1'b1, 6'd54};  // Down
            {1'b1, 8'h6B}: r = {1'b1, 6'd52};  // Left
            {1'b1, 8'h74}: r = {1'b1, 6'd53};  // Right
            default:       r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver in the mck domain.
//   mck        master clock
//   rin_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_dat    raw PS/2 data (asynchronous)
//   rx_byte    last received data byte (valid while byte_stb is high)
//   byte_stb   one-cycle strobe for a frame with good start/parity/stop
//   frame_err  one-cycle pulse on bad start, parity, stop or timeout
module ps2_rx
    import z88_kbd_pkg::*;
#(
    parameter int unsigned FILT_LEN = 8,
    parameter int unsigned TIMEOUT  = 9830
) (
    input  logic       mck,
    input  logic       rin_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err
);

    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_s, dat_s;
    logic          flt;
    logic [FW-1:0] flt_cnt;
    logic          fe;
    logic          timeout;

    rx_state_t     state, state_n;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          stb_n, err_n;

    assign clk_s = clk_sync[1];
    assign dat_s = dat_sync[1];

    // Lines idle high, so synchronisers and filter reset to 1
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
        end
    end

    // flt_cnt counts consecutive samples differing from flt; on the
    // FILT_LEN-th such sample flt flips, and fe marks that cycle for 1->0.
    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            flt     <= 1'b1;
            flt_cnt <= '0;
        end else if (clk_s == flt) begin
            flt_cnt <= '0;
        end else if (flt_cnt == FILT_LAST) begin
            flt     <= clk_s;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    assign fe      = flt && !clk_s && (flt_cnt == FILT_LAST);
    assign timeout = (state != RX_IDLE) && (to_cnt == TO_LAST);

    always_comb begin
        state_n = state;
        stb_n   = 1'b0;
        err_n   = 1'b0;
        if (fe) begin
            case (state)
                RX_IDLE: begin
                    if (!dat_s) state_n = RX_DATA;
                    else        err_n   = 1'b1;
                end
                RX_DATA: begin
                    if (bit_cnt == 3'd7) state_n = RX_PARITY;
                end
                RX_PARITY: state_n = RX_STOP;
                RX_STOP: begin
                    state_n = RX_IDLE;
                    if (dat_s && (^{shreg, par})) stb_n = 1'b1;
                    else                          err_n = 1'b1;
                end
                default: state_n = RX_IDLE;
            endcase
        end else if (timeout) begin
            state_n = RX_IDLE;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state     <= RX_IDLE;
            byte_stb  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            byte_stb  <= stb_n;
            frame_err <= err_n;
        end
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (fe) begin
                case (state)
                    RX_IDLE: bit_cnt <= '0;
                    RX_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    RX_PARITY: par <= dat_s;
                    default: ;
                endcase
            end
            if (fe || timeout || state == RX_IDLE) to_cnt <= '0;
            else                                   to_cnt <= to_cnt + 1'b1;
        end
    end

    // shreg is stable from the stop bit until the next frame's first data bit
    assign rx_byte = shreg;

endmodule

// File: rtl/ps2_kbmat.sv
// ps2_kbmat: PS/2 set-2 keyboard to Z88 64-bit key matrix.
//   mck        master clock (9.83 MHz)
//   rin_n      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock
//   ps2_dat    raw PS/2 data
//   kbmat      key matrix, bit 8*row+col, 1 = held
//   key_evt    one-cycle pulse when any kbmat bit changes
//   frame_err  one-cycle pulse on a receive error
module ps2_kbmat
    import z88_kbd_pkg::*;
#(
    parameter int unsigned FILT_LEN = 8,
    parameter int unsigned TIMEOUT  = 9830
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        key_evt,
    output logic        frame_err
);

    logic [7:0]  rx_byte;
    logic        byte_stb;

    dec_state_t  state, state_n;
    logic [2:0]  skip_cnt, skip_n;
    logic [63:0] kb_n;
    logic        evt_n;
    logic        do_key, make, ext;
    key_hit_t    hit;

    ps2_rx #(
        .FILT_LEN(FILT_LEN),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .mck      (mck),
        .rin_n    (rin_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .byte_stb (byte_stb),
        .frame_err(frame_err)
    );

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        do_key  = 1'b0;
        make    = 1'b0;
        ext     = 1'b0;
        kb_n    = kbmat;
        if (byte_stb) begin
            case (state)
                DEC_BASE: begin
                    if (rx_byte == SC_E0) begin
                        state_n = DEC_E0;
                    end else if (rx_byte == SC_F0) begin
                        state_n = DEC_F0;
                    end else if (rx_byte == SC_E1) begin
                        state_n = DEC_SKIP;
                        skip_n  = PAUSE_SKIP;
                    end else if (rx_byte == SC_AA || rx_byte == SC_OVR_00 ||
                                 rx_byte == SC_OVR_FF) begin
                        kb_n = '0;
                    end else begin
                        do_key = 1'b1;
                        make   = 1'b1;
                    end
                end
                DEC_E0: begin
                    if (rx_byte == SC_F0) begin
                        state_n = DEC_E0F0;
                    end else begin
                        state_n = DEC_BASE;
                        if (rx_byte != SC_FAKE_SHIFT) begin
                            do_key = 1'b1;
                            make   = 1'b1;
                            ext    = 1'b1;
                        end
                    end
                end
                DEC_F0: begin
                    state_n = DEC_BASE;
                    do_key  = 1'b1;
                end
                DEC_E0F0: begin
                    state_n = DEC_BASE;
                    do_key  = 1'b1;
                    ext     = 1'b1;
                end
                DEC_SKIP: begin
                    skip_n = skip_cnt - 1'b1;
                    if (skip_cnt == 3'd1) state_n = DEC_BASE;
                end
                default: state_n = DEC_BASE;
            endcase
        end
        hit = keymap(ext, rx_byte);
        if (do_key && hit.hit) kb_n[hit.idx] = make;
        // Typematic repeats and BAT with an empty matrix leave kb_n equal
        evt_n = (kb_n != kbmat);
    end

    always_ff @(posedge mck or negedge rin_n) begin
        if (!rin_n) begin
            state    <= DEC_BASE;
            skip_cnt <= '0;
            kbmat    <= '0;
            key_evt  <= 1'b0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
            kbmat    <= kb_n;
            key_evt  <= evt_n;
        end
    end

endmodule

// File: tb/tb_ps2_kbmat.sv
// tb_ps2_kbmat: scoreboard bench for ps2_kbmat. Frames are bit-banged on
// the PS/2 lines; expected events (kind, matrix, arrival cycle) are queued
// at the stop-bit clock fall and checked by an independent monitor.
module tb_ps2_kbmat;

    localparam int K_KEY = 1;
    localparam int K_ERR = 2;
    localparam int LAT_KEY = 11;  // 2 sync + 8 filter + strobe + matrix
    localparam int LAT_ERR = 10;

    logic        mck = 1'b0;
    logic        rin_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [63:0] kbmat;
    logic        key_evt;
    logic        frame_err;

    ps2_kbmat #(
        .FILT_LEN(8),
        .TIMEOUT (9830)
    ) dut (
        .mck      (mck),
        .rin_n    (rin_n),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .kbmat    (kbmat),
        .key_evt  (key_evt),
        .frame_err(frame_err)
    );

    always #5 mck = ~mck;

    longint cyc = 0;
    always @(posedge mck) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [63:0] kb;
        longint      at;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    function automatic logic [63:0] bit_of(input int n);
        logic [63:0] one;
        one = 64'd1;
        return one << n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every key_evt / frame_err pulse must match the queue head
    always @(negedge mck) begin
        if (rin_n && (key_evt === 1'b1 || frame_err === 1'b1)) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: key_evt=%b frame_err=%b kbmat=%h at cycle %0d, expected none",
                         key_evt, frame_err, kbmat, cyc);
            end else begin
                exp_t e;
                int kind;
                e = sb.pop_front();
                kind = (key_evt && frame_err) ? 3 : (key_evt ? K_KEY : K_ERR);
                check("evt_kind", 64'(kind), 64'(e.kind));
                check("evt_cycle", 64'(cyc), 64'(e.at));
                if (e.kind == K_KEY) check("evt_kbmat", kbmat, e.kb);
            end
        end
    end

    // One PS/2 clock period; optionally queues the event this falling edge causes
    task automatic clk_pulse(input logic v, input int kind, input logic [63:0] kb, input int lat);
        ps2_dat = v;
        repeat (15) @(posedge mck);
        #1 ps2_clk = 1'b0;
        if (kind != 0) sb.push_back('{kind, kb, cyc + lat});
        repeat (30) @(posedge mck);
        #1 ps2_clk = 1'b1;
        repeat (15) @(posedge mck);
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind, input logic [63:0] kb,
                              input logic flip_par, input logic bad_stop);
        clk_pulse(1'b0, 0, '0, 0);
        for (int i = 0; i < 8; i++) clk_pulse(b[i], 0, '0, 0);
        clk_pulse(~(^b) ^ flip_par, 0, '0, 0);
        clk_pulse(~bad_stop, kind, kb, (kind == K_KEY) ? LAT_KEY : LAT_ERR);
    endtask

    task automatic key(input logic [7:0] b, input logic [63:0] kb);
        send_frame(b, K_KEY, kb, 1'b0, 1'b0);
    endtask

    task automatic quiet(input logic [7:0] b);
        send_frame(b, 0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (5) @(posedge mck);
        #1;
        check("reset_kbmat", kbmat, '0);
        check("reset_key_evt", 64'(key_evt), 64'd0);
        check("reset_frame_err", 64'(frame_err), 64'd0);
        @(negedge mck) rin_n = 1'b1;
        repeat (20) @(posedge mck);

        // BAT with empty matrix: no event
        quiet(8'hAA);

        // Press / release A
        key(8'h1C, bit_of(30));
        quiet(8'hF0);
        key(8'h1C, '0);

        // Typematic: only the first make reports
        key(8'h1C, bit_of(30));
        quiet(8'h1C);
        quiet(8'h1C);
        #1 check("typematic_kbmat", kbmat, bit_of(30));
        quiet(8'hF0);
        key(8'h1C, '0);

        // Extended Up, fake shift ignored, extended release
        quiet(8'hE0);
        key(8'h75, bit_of(55));
        quiet(8'hE0);
        quiet(8'h12);
        #1 check("fake_shift_kbmat", kbmat, bit_of(55));
        quiet(8'hE0);
        quiet(8'hF0);
        key(8'h75, '0);

        // Parity error then good Enter
        send_frame(8'h5A, K_ERR, '0, 1'b1, 1'b0);
        #1 check("parity_err_kbmat", kbmat, '0);
        key(8'h5A, bit_of(6));
        quiet(8'hF0);
        key(8'h5A, '0);

        // Timeout: start + 3 data bits then silence
        clk_pulse(1'b0, 0, '0, 0);
        clk_pulse(1'b1, 0, '0, 0);
        clk_pulse(1'b0, 0, '0, 0);
        clk_pulse(1'b1, K_ERR, '0, LAT_ERR + 9830);
        repeat (10000) @(posedge mck);
        key(8'h29, bit_of(46));
        quiet(8'hF0);
        key(8'h29, '0);

        // Both shifts, BAT clears, pause swallowed
        key(8'h12, bit_of(62));
        key(8'h59, bit_of(62) | bit_of(63));
        key(8'hAA, '0);
        foreach (pause_seq[i]) quiet(pause_seq[i]);
        #1 check("pause_kbmat", kbmat, '0);
        key(8'h1C, bit_of(30));

        // Bad stop bit
        send_frame(8'h1C, K_ERR, '0, 1'b0, 1'b1);
        #1 check("bad_stop_kbmat", kbmat, bit_of(30));

        // Reset in the middle of a frame
        clk_pulse(1'b0, 0, '0, 0);
        clk_pulse(1'b1, 0, '0, 0);
        ps2_dat = 1'b0;
        repeat (15) @(posedge mck);
        #1 ps2_clk = 1'b0;
        repeat (4) @(posedge mck);
        #3 rin_n = 1'b0;
        #1;
        check("midreset_kbmat", kbmat, '0);
        check("midreset_key_evt", 64'(key_evt), 64'd0);
        check("midreset_frame_err", 64'(frame_err), 64'd0);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (10) @(posedge mck);
        @(negedge mck) rin_n = 1'b1;
        repeat (20) @(posedge mck);
        key(8'h1C, bit_of(30));

        repeat (50) @(posedge mck);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
